alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Request-side controller that drives the combinational 15-bit sign-format ALU. It accepts one operation per valid/ready handshake and issues the matching 3-bit ALU command or commands. For MUL and DIV it issues two commands back to back. It captures each ALU result after a programmable settle time and returns a single response with low and high halves. It sits between the datapath issue logic and the ALU and owns all ALU input ports.

## Interface
- SETTLE, 1: cycles the ALU inputs are held before the result is sampled; legal range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; reset 0, then 1 in IDLE.
- req_op  in  3  0 ADD, 1 SUB, 2 AND, 3 MUL, 4 DIV, 5..7 illegal.
- req_a, req_b  in  16  operands in ALU input format: bit 15 sign, bits [15:1] value field.
- alu_a, alu_b  out  16  operands to ALU; reset 0.
- alu_command  out  3  command to ALU; reset 0.
- alu_res  in  15  ALU result.
- rsp_valid  out  1  response present; reset 0.
- rsp_ready  in  1  response consumed.
- rsp_lo, rsp_hi  out  15  result halves; reset 0.
- rsp_err  out  1  illegal op or zero divisor; reset 0.

## Operation
- States: IDLE, ISSUE0, ISSUE1, RESP.
- req_ready is 1 only in IDLE. A request is accepted when req_valid && req_ready.
- On accept:
  - req_a and req_b are latched and driven onto alu_a and alu_b.
  - The first command is latched and driven on alu_command.
  - The settle counter is cleared.
- Command mapping:
  - ADD issues 0, SUB issues 1, AND issues 2. Each is single phase: ISSUE0 then RESP.
  - MUL issues 3 then 4: rsp_lo = ALU MP0 result, rsp_hi = MP1 result (product bits [14:0] and [29:15]).
  - DIV issues 6 then 5: rsp_lo = quotient, rsp_hi = remainder.
  - For single-phase ops, rsp_hi = 0.
- Zero-divisor check for DIV: the divisor is zero when req_b[15:1] == 15'h0000 or req_b[15:1] == 15'h7FFF.
  - On a zero divisor, go IDLE -> RESP directly with rsp_err = 1 and rsp_lo = rsp_hi = 0. No command 5 or 6 is ever issued.
- Illegal op (5..7): same as zero divisor, IDLE -> RESP directly with rsp_err = 1, rsp_lo = rsp_hi = 0, no command issued.
- Settle and capture in ISSUEn:
  - The counter increments every cycle.
  - On the edge where the counter equals SETTLE-1, alu_res is captured into the target half and the counter clears.
  - The FSM then moves to ISSUE1 (with the second command driven) or to RESP.
- RESP:
  - rsp_valid = 1.
  - rsp_lo, rsp_hi, rsp_err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE. rsp_valid drops and the rsp_* registers keep their values.
- alu_a, alu_b, alu_command hold their last driven values in RESP and IDLE. They change only on accept or on the ISSUE0 -> ISSUE1 transition.
- Reset asserted in any state:
  - State goes to IDLE at once; the in-flight op is dropped.
  - All outputs return to reset values.
  - req_ready becomes 1 on the first clk edge after reset deasserts.

## Timing
- Acceptance edge = t0.
- Single-phase op: rsp_valid is high after edge t0+SETTLE.
- Two-phase op: the second command is driven from edge t0+SETTLE; rsp_valid is high after edge t0+2*SETTLE.
- Error response: rsp_valid is high after edge t0+1.
- Earliest next accept is the edge after the rsp handshake edge. There is no overlap, so throughput is one op per latency+2 cycles minimum.
- rsp_ready held high before rsp_valid: the handshake completes on the first RESP cycle.
- req_valid while not in IDLE is ignored; the requester must hold it until req_ready.

## Test plan
- ADD, SETTLE=1: req_a=16'h0004, req_b=16'h0006 -> alu_command=0 for 1 cycle; rsp_lo=15'd5, rsp_hi=0, rsp_err=0; rsp_valid after t0+1.
- MUL, SETTLE=2: req_a=req_b=16'h0200 -> alu_command 3 for 2 cycles, then 4 for 2 cycles; rsp_lo=0, rsp_hi=15'd2; rsp_valid after t0+4.
- DIV: req_a=16'h000E, req_b=16'h0004 -> commands 6 then 5; rsp_lo=3, rsp_hi=1.
- DIV with zero divisor:
  - req_b=16'h0001 -> rsp_err=1 after t0+1; alu_command never 5 or 6.
  - Repeat with req_b=16'hFFFF -> same response.
- Illegal op and backpressure:
  - req_op=7 -> rsp_err=1, rsp_lo=rsp_hi=0.
  - Hold rsp_ready=0 for 5 cycles -> rsp_* stable and req_ready=0 throughout; the accept after the handshake succeeds.
- Reset mid-MUL: assert reset during ISSUE1 -> all outputs 0 immediately, no response emitted; after release, an ADD of 4+6 completes normally.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Issues one or two ALU commands per accepted request and returns the
// captured results as a single lo/hi response.
module alu_op_sequencer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_command,
    input  logic [14:0] alu_res,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [14:0] rsp_lo,
    output logic [14:0] rsp_hi,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE0,
        ISSUE1,
        RESP
    } state_t;

    localparam logic [3:0] LAST = 4'(SETTLE - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  cnt;
    logic        two_q;
    logic [2:0]  cmd1_q;
    logic        accept;
    logic        settled;
    logic        legal;
    logic        two;
    logic        zero_div;
    logic        err_req;
    logic [2:0]  cmd0;
    logic [2:0]  cmd1;

    assign accept    = req_valid && req_ready;
    assign settled   = (cnt == LAST);
    assign rsp_valid = (state == RESP);

    // 15'h7FFF is the negative-zero encoding, so it counts as zero too
    assign zero_div = (req_op == 3'd4) &&
                      ((req_b[15:1] == 15'h0000) ||
                       (req_b[15:1] == 15'h7FFF));
    assign err_req  = !legal || zero_div;

    always_comb begin
        cmd0  = 3'd0;
        cmd1  = 3'd0;
        two   = 1'b0;
        legal = 1'b1;
        unique case (req_op)
            3'd0: cmd0 = 3'd0;
            3'd1: cmd0 = 3'd1;
            3'd2: cmd0 = 3'd2;
            3'd3: begin
                cmd0 = 3'd3;
                cmd1 = 3'd4;
                two  = 1'b1;
            end
            3'd4: begin
                cmd0 = 3'd6;
                cmd1 = 3'd5;
                two  = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    next_state = err_req ? RESP : ISSUE0;
            end
            ISSUE0: begin
                if (settled)
                    next_state = two_q ? ISSUE1 : RESP;
            end
            ISSUE1: begin
                if (settled)
                    next_state = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready   <= 1'b0;
            alu_a       <= 16'h0000;
            alu_b       <= 16'h0000;
            alu_command <= 3'd0;
            rsp_lo      <= 15'h0000;
            rsp_hi      <= 15'h0000;
            rsp_err     <= 1'b0;
            cnt         <= 4'd0;
            two_q       <= 1'b0;
            cmd1_q      <= 3'd0;
        end else begin
            // registered so it stays low until the first edge after reset
            req_ready <= (next_state == IDLE);
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a  <= req_a;
                        alu_b  <= req_b;
                        cnt    <= 4'd0;
                        two_q  <= two;
                        cmd1_q <= cmd1;
                        rsp_hi <= 15'h0000;
                        if (err_req) begin
                            rsp_err <= 1'b1;
                            rsp_lo  <= 15'h0000;
                        end else begin
                            rsp_err     <= 1'b0;
                            alu_command <= cmd0;
                        end
                    end
                end
                ISSUE0: begin
                    if (settled) begin
                        cnt    <= 4'd0;
                        rsp_lo <= alu_res;
                        if (two_q)
                            alu_command <= cmd1_q;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ISSUE1: begin
                    if (settled) begin
                        cnt    <= 4'd0;
                        rsp_hi <= alu_res;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: SETTLE=1 instance for the single-cycle ADD case,
// SETTLE=2 instance for everything else, each with a behavioural ALU.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;

    logic        rv1, rr1, rdy1, vld1, err1;
    logic [15:0] aa1, ab1;
    logic [2:0]  cmd1;
    logic [14:0] res1, lo1, hi1;

    logic        rv2, rr2, rdy2, vld2, err2;
    logic [15:0] aa2, ab2;
    logic [2:0]  cmd2;
    logic [14:0] res2, lo2, hi2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function automatic logic [14:0] alu_f(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [2:0] c);
        logic [14:0] x;
        logic [14:0] y;
        logic [29:0] p;
        x = a[15:1];
        y = b[15:1];
        p = 30'(x) * 30'(y);
        case (c)
            3'd0: return x + y;
            3'd1: return x - y;
            3'd2: return x & y;
            3'd3: return p[14:0];
            3'd4: return p[29:15];
            3'd5: return (y == 15'd0) ? 15'd0 : x % y;
            3'd6: return (y == 15'd0) ? 15'd0 : x / y;
            default: return 15'd0;
        endcase
    endfunction

    assign res1 = alu_f(aa1, ab1, cmd1);
    assign res2 = alu_f(aa2, ab2, cmd2);

    alu_op_sequencer #(.SETTLE(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(rv1), .req_ready(rdy1),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_a(aa1), .alu_b(ab1), .alu_command(cmd1),
        .alu_res(res1),
        .rsp_valid(vld1), .rsp_ready(rr1),
        .rsp_lo(lo1), .rsp_hi(hi1), .rsp_err(err1)
    );

    alu_op_sequencer #(.SETTLE(2)) dut2 (
        .clk(clk), .reset(reset),
        .req_valid(rv2), .req_ready(rdy2),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_a(aa2), .alu_b(ab2), .alu_command(cmd2),
        .alu_res(res2),
        .rsp_valid(vld2), .rsp_ready(rr2),
        .rsp_lo(lo2), .rsp_hi(hi2), .rsp_err(err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        rv1 = 1'b0; rr1 = 1'b0; rv2 = 1'b0; rr2 = 1'b0;
        req_op = 3'd0; req_a = 16'h0; req_b = 16'h0;
        step(); step();
        chk("rst_ready2", 32'(rdy2), 0);
        chk("rst_ready1", 32'(rdy1), 0);
        chk("rst_valid2", 32'(vld2), 0);
        chk("rst_cmd2", 32'(cmd2), 0);
        chk("rst_alu_a2", 32'(aa2), 0);
        chk("rst_lo2", 32'(lo2), 0);
        chk("rst_err2", 32'(err2), 0);
        reset = 1'b0;
        step();
        chk("post_rst_ready1", 32'(rdy1), 1);
        chk("post_rst_ready2", 32'(rdy2), 1);

        // ADD on SETTLE=1
        req_op = 3'd0; req_a = 16'h0004; req_b = 16'h0006; rv1 = 1'b1;
        step(); rv1 = 1'b0;
        chk("add1_cmd", 32'(cmd1), 0);
        chk("add1_alu_b", 32'(ab1), 32'h6);
        chk("add1_valid_t0", 32'(vld1), 0);
        step();
        chk("add1_valid_t1", 32'(vld1), 1);
        chk("add1_lo", 32'(lo1), 5);
        chk("add1_hi", 32'(hi1), 0);
        chk("add1_err", 32'(err1), 0);
        rr1 = 1'b1;
        step(); rr1 = 1'b0;
        chk("add1_valid_drop", 32'(vld1), 0);
        chk("add1_ready_back", 32'(rdy1), 1);
        chk("add1_lo_kept", 32'(lo1), 5);

        // MUL on SETTLE=2
        req_op = 3'd3; req_a = 16'h0200; req_b = 16'h0200; rv2 = 1'b1;
        step(); rv2 = 1'b0;
        chk("mul_cmd_t0", 32'(cmd2), 3);
        chk("mul_ready_busy", 32'(rdy2), 0);
        step();
        chk("mul_cmd_t1", 32'(cmd2), 3);
        chk("mul_valid_t1", 32'(vld2), 0);
        step();
        chk("mul_cmd_t2", 32'(cmd2), 4);
        step();
        chk("mul_cmd_t3", 32'(cmd2), 4);
        chk("mul_valid_t3", 32'(vld2), 0);
        step();
        chk("mul_valid_t4", 32'(vld2), 1);
        chk("mul_lo", 32'(lo2), 0);
        chk("mul_hi", 32'(hi2), 2);
        chk("mul_err", 32'(err2), 0);
        rr2 = 1'b1;
        step(); rr2 = 1'b0;
        chk("mul_valid_drop", 32'(vld2), 0);

        // DIV by zero (positive zero)
        req_op = 3'd4; req_a = 16'h000E; req_b = 16'h0001; rv2 = 1'b1;
        step(); rv2 = 1'b0;
        chk("dz0_valid", 32'(vld2), 1);
        chk("dz0_err", 32'(err2), 1);
        chk("dz0_lo", 32'(lo2), 0);
        chk("dz0_hi", 32'(hi2), 0);
        chk("dz0_no_div_cmd", 32'(cmd2 == 3'd5 || cmd2 == 3'd6), 0);
        rr2 = 1'b1;
        step(); rr2 = 1'b0;
        chk("dz0_valid_drop", 32'(vld2), 0);

        // DIV by negative zero, rsp_ready already high
        req_b = 16'hFFFF; rv2 = 1'b1; rr2 = 1'b1;
        step(); rv2 = 1'b0;
        chk("dz1_valid", 32'(vld2), 1);
        chk("dz1_err", 32'(err2), 1);
        chk("dz1_hi", 32'(hi2), 0);
        chk("dz1_no_div_cmd", 32'(cmd2 == 3'd5 || cmd2 == 3'd6), 0);
        step(); rr2 = 1'b0;
        chk("dz1_valid_drop", 32'(vld2), 0);
        chk("dz1_ready_back", 32'(rdy2), 1);

        // Illegal op held under backpressure; a DIV waits behind it
        req_op = 3'd7; req_a = 16'h1234; req_b = 16'h0042; rv2 = 1'b1;
        step();
        req_op = 3'd4; req_a = 16'h000E; req_b = 16'h0004;
        for (int i = 0; i < 5; i++) begin
            chk("ill_valid_hold", 32'(vld2), 1);
            chk("ill_err_hold", 32'(err2), 1);
            chk("ill_lo_hold", 32'(lo2), 0);
            chk("ill_ready_low", 32'(rdy2), 0);
            step();
        end
        rr2 = 1'b1;
        step(); rr2 = 1'b0;
        chk("ill_valid_drop", 32'(vld2), 0);
        chk("ill_ready_back", 32'(rdy2), 1);
        step(); rv2 = 1'b0;
        chk("div_cmd_t0", 32'(cmd2), 6);
        chk("div_ready_busy", 32'(rdy2), 0);
        step();
        chk("div_cmd_t1", 32'(cmd2), 6);
        step();
        chk("div_cmd_t2", 32'(cmd2), 5);
        step();
        chk("div_valid_t3", 32'(vld2), 0);
        step();
        chk("div_valid_t4", 32'(vld2), 1);
        chk("div_lo", 32'(lo2), 3);
        chk("div_hi", 32'(hi2), 1);
        chk("div_err", 32'(err2), 0);
        rr2 = 1'b1;
        step(); rr2 = 1'b0;

        // Reset in the middle of a MUL
        req_op = 3'd3; req_a = 16'h0200; req_b = 16'h0200; rv2 = 1'b1;
        step(); rv2 = 1'b0;
        step(); step();
        chk("mid_cmd_issue1", 32'(cmd2), 4);
        reset = 1'b1;
        #1;
        chk("mid_rst_cmd", 32'(cmd2), 0);
        chk("mid_rst_alu_a", 32'(aa2), 0);
        chk("mid_rst_alu_b", 32'(ab2), 0);
        chk("mid_rst_valid", 32'(vld2), 0);
        chk("mid_rst_ready", 32'(rdy2), 0);
        chk("mid_rst_lo", 32'(lo2), 0);
        chk("mid_rst_hi", 32'(hi2), 0);
        chk("mid_rst_err", 32'(err2), 0);
        step();
        reset = 1'b0;
        chk("rel_ready_low", 32'(rdy2), 0);
        step();
        chk("rel_ready_high", 32'(rdy2), 1);
        chk("rel_no_rsp", 32'(vld2), 0);

        req_op = 3'd0; req_a = 16'h0004; req_b = 16'h0006; rv2 = 1'b1;
        step(); rv2 = 1'b0;
        chk("add2_cmd", 32'(cmd2), 0);
        step();
        chk("add2_valid_t1", 32'(vld2), 0);
        step();
        chk("add2_valid_t2", 32'(vld2), 1);
        chk("add2_lo", 32'(lo2), 5);
        chk("add2_hi", 32'(hi2), 0);
        chk("add2_err", 32'(err2), 0);
        rr2 = 1'b1;
        step(); rr2 = 1'b0;
        chk("add2_done", 32'(rdy2), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
